xregs_apb_frontend: RTL and testbench

//  APB-style bus front end of the xregs register bank; sits directly upstream of the per-word access slices.

---
 rtl/xregs_pkg.sv | 14 +
 rtl/xregs_timeout_counter.sv | 40 ++++
 rtl/xregs_apb_frontend.sv | 167 ++++++++++++++++
 tb/tb_xregs_apb_frontend.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/xregs_pkg.sv
// Shared types and constants for the xregs register-bank front end.
package xregs_pkg;

    // Front-end transfer FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fe_state_t;

    // The bus carries byte addresses; slices are addressed by 32-bit word.
    localparam int unsigned BYTE_SHIFT = 2;

endpackage

// File: rtl/xregs_timeout_counter.sv
// Cycle counter for the REQ state of the xregs front end.
// It is cleared while clr_i is high and counts while en_i is high.
// expired_o flags the last permitted request cycle (count == TIMEOUT-1).
module xregs_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority, then increment, saturating at the limit.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_W'(TIMEOUT - 1))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/xregs_apb_frontend.sv
// APB front end of the xregs register bank.
// Turns one APB transfer into a held word address / request / write / wdata
// for the per-word slices, collects their acks and answers the bus with a
// one-cycle pready plus prdata and pslverr.
// Optional feature macro: XREGS_FRONTEND_TIMEOUT_EN adds a request timeout
// that aborts the slices and returns an error. Without it REQ waits forever
// for an ack and abort stays 0.
module xregs_apb_frontend
    import xregs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH+1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic                    request,
    output logic                    write,
    output logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [NUM_WORDS-1:0]    qualified_ack,
    output logic                    ack_comb,
    output logic                    abort
);

    fe_state_t               state_q,   state_d;
    logic                    request_q, request_d;
    logic                    abort_q,   abort_d;
    logic                    pready_q,  pready_d;
    logic                    pslverr_q, pslverr_d;
    logic                    write_q,   write_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [DATA_WIDTH-1:0]   prdata_q,  prdata_d;

    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    in_range;
    logic                    setup_phase;
    logic                    timeout_hit;
    logic                    unused_byte_lane;

    // The byte-lane bits of paddr carry no information for word slices.
    assign unused_byte_lane = ^paddr[BYTE_SHIFT-1:0];

    assign word_addr   = paddr[ADDR_WIDTH+BYTE_SHIFT-1:BYTE_SHIFT];
    assign in_range    = (ADDR_WIDTH+1)'(word_addr) < (ADDR_WIDTH+1)'(NUM_WORDS);
    // Requiring penable=0 keeps a held access phase from starting a new transfer.
    assign setup_phase = psel && !penable;
    assign ack_comb    = |qualified_ack;

`ifdef XREGS_FRONTEND_TIMEOUT_EN
    // Counter is held at zero outside REQ, so it starts from 0 on every entry.
    xregs_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q != REQ),
        .en_i      (state_q == REQ),
        .expired_o (timeout_hit)
    );
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    // Next-state and registered-output logic for the transfer FSM.
    always_comb begin
        state_d   = state_q;
        request_d = request_q;
        abort_d   = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        write_d   = write_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;

        case (state_q)
            IDLE: begin
                if (setup_phase) begin
                    address_d = word_addr;
                    write_d   = pwrite;
                    wdata_d   = pwdata;
                    if (in_range) begin
                        state_d   = REQ;
                        request_d = 1'b1;
                    end else begin
                        // Out-of-range words never reach the slices.
                        state_d   = DONE;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end
                end
            end
            REQ: begin
                // An ack in the timeout cycle still completes normally.
                if (ack_comb) begin
                    state_d   = DONE;
                    request_d = 1'b0;
                    pready_d  = 1'b1;
                    if (!write_q) begin
                        prdata_d = rdata;
                    end
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    request_d = 1'b0;
                    abort_d   = 1'b1;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                request_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset returns to IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            request_q <= 1'b0;
            abort_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            write_q   <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            request_q <= request_d;
            abort_q   <= abort_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            write_q   <= write_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
        end
    end

    assign request = request_q;
    assign abort   = abort_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign write   = write_q;
    assign address = address_q;
    assign wdata   = wdata_q;
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_xregs_apb_frontend.sv
// Directed bench for xregs_apb_frontend (default parameters).
// Timeout scenarios are selected by XREGS_FRONTEND_TIMEOUT_EN.
module tb_xregs_apb_frontend;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            psel, penable, pwrite;
    logic [AW+1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic            pready;
    logic [DW-1:0]   prdata;
    logic            pslverr;
    logic [AW-1:0]   address;
    logic            request, write;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    logic [NW-1:0]   qualified_ack;
    logic            ack_comb;
    logic            abort;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xregs_apb_frontend #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .TIMEOUT    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .psel          (psel),
        .penable       (penable),
        .pwrite        (pwrite),
        .paddr         (paddr),
        .pwdata        (pwdata),
        .pready        (pready),
        .prdata        (prdata),
        .pslverr       (pslverr),
        .address       (address),
        .request       (request),
        .write         (write),
        .wdata         (wdata),
        .rdata         (rdata),
        .qualified_ack (qualified_ack),
        .ack_comb      (ack_comb),
        .abort         (abort)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One APB transfer starting with its setup phase in the current cycle (T0).
    // ack_cyc: cycle index (T1 = 1) in which the slice acks; -1 means never.
    task automatic xfer(input string tag, input bit wr, input logic [AW+1:0] pa,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                        input int ack_cyc, input int exp_rdy_cyc, input int exp_req_cnt,
                        input bit exp_err, input bit exp_abort, input logic [DW-1:0] exp_prdata);
        int n;
        int req_cnt;
        int abort_cnt;
        int unstable;
        int rdy_cyc;
        logic [AW-1:0] exp_addr;
        exp_addr  = pa[AW+1:2];
        req_cnt   = 0;
        abort_cnt = 0;
        unstable  = 0;
        rdy_cyc   = -1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = pa; pwdata = wd;
        qualified_ack = '0;
        tick();
        penable = 1'b1;
        // Scramble bus data after setup; the latched copies must not follow.
        pwdata = ~wd;
        pwrite = ~wr;
        n = 1;
        while (rdy_cyc < 0 && n <= 100) begin
            if (n == ack_cyc) begin
                qualified_ack = NW'(1) << exp_addr[2:0];
                rdata = rd;
                #1;
                chk({tag, "_ack_comb"}, 64'(ack_comb), 64'(1));
            end else begin
                qualified_ack = '0;
                rdata = ~rd;
            end
            if (request) req_cnt++;
            if (abort) abort_cnt++;
            if (request || pready) begin
                if (write !== wr || wdata !== wd || address !== exp_addr) unstable++;
            end
            if (pready) begin
                rdy_cyc = n;
                chk({tag, "_pslverr"}, 64'(pslverr), 64'(exp_err));
                chk({tag, "_abort"}, 64'(abort), 64'(exp_abort));
                chk({tag, "_prdata"}, 64'(prdata), 64'(exp_prdata));
            end else begin
                tick();
                n++;
            end
        end
        qualified_ack = '0;
        chk({tag, "_pready_cycle"}, 64'(rdy_cyc), 64'(exp_rdy_cyc));
        chk({tag, "_req_cycles"}, 64'(req_cnt), 64'(exp_req_cnt));
        chk({tag, "_abort_cycles"}, 64'(abort_cnt), 64'(exp_abort));
        chk({tag, "_held_fields"}, 64'(unstable), 64'(0));
        tick();
        chk({tag, "_pready_pulse"}, 64'(pready), 64'(0));
        chk({tag, "_abort_clear"}, 64'(abort), 64'(0));
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; rdata = '0; qualified_ack = '0;
        #1;
        chk("rst_request", 64'(request), 64'(0));
        chk("rst_abort",   64'(abort),   64'(0));
        chk("rst_pready",  64'(pready),  64'(0));
        chk("rst_pslverr", 64'(pslverr), 64'(0));
        chk("rst_write",   64'(write),   64'(0));
        chk("rst_address", 64'(address), 64'(0));
        chk("rst_wdata",   64'(wdata),   64'(0));
        chk("rst_prdata",  64'(prdata),  64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic read and write, immediate ack at T2, pready at T3.
        xfer("rd_w3", 1'b0, 18'd12, 32'h0, 32'hA5A5_0003, 2, 3, 2, 1'b0, 1'b0, 32'hA5A5_0003);
        tick();
        xfer("wr_w1", 1'b1, 18'd4, 32'h1234_5678, 32'hDEAD_BEEF, 2, 3, 2, 1'b0, 1'b0, 32'hA5A5_0003);
        tick();
        // Out of range word 8: no request, pready at T1 with error.
        xfer("oor_w8", 1'b0, 18'd32, 32'h0, 32'h1111_1111, -1, 1, 0, 1'b1, 1'b0, 32'hA5A5_0003);
        tick();
        // Byte-lane bits ignored (byte 23 is word 5); slower ack.
        xfer("rd_w5", 1'b0, 18'd23, 32'h0, 32'h0000_0055, 4, 5, 4, 1'b0, 1'b0, 32'h0000_0055);
        tick();
        // Highest in-range word.
        xfer("rd_w7", 1'b0, 18'd28, 32'h0, 32'h7777_0007, 2, 3, 2, 1'b0, 1'b0, 32'h7777_0007);

        // Held access phase must not start a transfer.
        psel = 1'b1; penable = 1'b1; paddr = 18'd8;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_access_req", 64'(request), 64'(0));
        end
        psel = 1'b0; penable = 1'b0;
        tick();

`ifdef XREGS_FRONTEND_TIMEOUT_EN
        // No ack: 16 request cycles, then abort with pready and error.
        xfer("tmo_none", 1'b0, 18'd8, 32'h0, 32'h2222_2222, -1, 17, 16, 1'b1, 1'b1, 32'h7777_0007);
        tick();
        // Ack in the timeout cycle wins.
        xfer("tmo_ack16", 1'b0, 18'd8, 32'h0, 32'h3333_0016, 16, 17, 16, 1'b0, 1'b0, 32'h3333_0016);
        tick();
`else
        // No timeout: the request waits for the ack at cycle 40.
        xfer("slow_ack40", 1'b0, 18'd8, 32'h0, 32'h4444_0040, 40, 41, 40, 1'b0, 1'b0, 32'h4444_0040);
        tick();
`endif

        // Reset while in REQ drops request immediately.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 18'd16;
        tick();
        penable = 1'b1;
        chk("mid_rst_req_before", 64'(request), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_after", 64'(request), 64'(0));
        psel = 1'b0; penable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        xfer("post_rst_rd", 1'b0, 18'd16, 32'h0, 32'h5555_0004, 2, 3, 2, 1'b0, 1'b0, 32'h5555_0004);

        // Back-to-back: write setup in the cycle right after the read's pready.
        tick();
        xfer("b2b_rd", 1'b0, 18'd0, 32'h0, 32'h6666_0000, 2, 3, 2, 1'b0, 1'b0, 32'h6666_0000);
        xfer("b2b_wr", 1'b1, 18'd24, 32'hCAFE_F00D, 32'h0, 2, 3, 2, 1'b0, 1'b0, 32'h6666_0000);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
